axi4l_ram_gen: RTL and testbench
================================

Name: axi4l_ram_gen

Overview:
- Parametrised AXI4-Lite slave RAM for the SoC fabric.
- Configurable data width, depth and address width.
- Separate write and read paths, each sustaining one transaction per cycle.
- Out-of-range decode returns SLVERR.
- Build-time optional write-protected low region for boot images.
- Intended as the general-purpose on-chip RAM/ROM slave behind the AXI4-Lite interconnect.

Parameters:
- DATA_W, 32, data bus width in bits; legal values 32 or 64.
- SIZE_BYTES, 'h80, RAM size in bytes; power of two, at least 2*DATA_W/8.
- ADDR_W, 32, AXI address width; must satisfy ADDR_W >= $clog2(SIZE_BYTES).
- RO_BYTES, 'h0, size of write-protected region starting at byte address 0; used only with AXI4L_RAM_RO_EN; multiple of DATA_W/8 and <= SIZE_BYTES.
- INIT_FILE, "", hex image loaded with $readmemh at elaboration when non-empty.

Ports:
- aclk  in  1  clock.
- aresetn  in  1  synchronous active-low reset.
- awaddr  in  ADDR_W  write address.
- awvalid  in  1  write address valid.
- awready  out  1  write address ready.
- wdata  in  DATA_W  write data.
- wstrb  in  DATA_W/8  byte strobes.
- wvalid  in  1  write data valid.
- wready  out  1  write data ready.
- bresp  out  2  write response.
- bvalid  out  1  write response valid.
- bready  in  1  write response ready.
- araddr  in  ADDR_W  read address.
- arvalid  in  1  read address valid.
- arready  out  1  read address ready.
- rdata  out  DATA_W  read data.
- rresp  out  2  read response.
- rvalid  out  1  read valid.
- rready  in  1  read ready.

Behaviour:
- Reset (aresetn=0 sampled at aclk): awready=wready=arready=1, bvalid=rvalid=0, bresp=rresp=OKAY (2'b00), rdata=0. Memory contents are not reset. Reset asserted mid-transaction discards any held address/data and any pending response.
- Addressing: LSB = $clog2(DATA_W/8). Word index = addr[$clog2(SIZE_BYTES)-1:LSB]. addr[LSB-1:0] are ignored (unaligned access is treated as aligned). Out of range when addr >= SIZE_BYTES (any upper bit set). AxPROT is not implemented.
- Write, AW and W captured independently:
  - Each channel has a one-entry hold register.
  - awready drops the cycle after AW is accepted without a matching W, or when the write cannot fire. It rises again once the held address is consumed. wready behaves symmetrically.
  - Write fires when an address (held or presented) and data (held or presented) are both available and (!bvalid || bready).
  - On fire: bytes with wstrb[i]=1 are written if in range. bvalid=1 on the next cycle, with bresp=OKAY or SLVERR (2'b10).
  - Out-of-range write: memory unchanged.
  - AW and W arriving together with no B stall: zero hold, response 1 cycle later, back-to-back throughput 1/cycle.
  - AW arriving N cycles before W (or the reverse): the write fires in the cycle the second arrives.
  - B stalled (bvalid && !bready): at most one AW and one W are accepted and held, then awready=wready=0 until the stall clears.
- Read:
  - Read fires when an address (held or presented) is available and (!rvalid || rready).
  - rdata/rresp/rvalid update on the next cycle (latency 1).
  - Out-of-range read: rdata=0, rresp=SLVERR.
  - During an R stall: one AR is accepted and held, then arready=0. arready rises the cycle after the held address is consumed. Throughput 1/cycle when rready is held high.
  - rdata is stable while rvalid && !rready.
- Collision (read and write firing to the same word in the same cycle): read returns old (pre-write) data.
- Read and write paths are fully independent; neither blocks the other.

Optional Feature:
- Macro AXI4L_RAM_RO_EN.
- Defined: writes to addr < RO_BYTES do not modify memory and return bresp=SLVERR; reads there behave normally.
- Undefined: RO_BYTES is ignored; the whole in-range space is writable.

Test Plan:
- DATA_W=32, SIZE_BYTES='h80: AW+W same cycle, awaddr=0x10, wdata=0xDEADBEEF, wstrb=4'hF, bready=1 -> bvalid 1 cycle later, bresp=00; read 0x10 -> rvalid 1 cycle after AR, rdata=0xDEADBEEF.
- Partial strobe: write 0x11223344 to 0x20, then wstrb=4'b0101 with wdata=0xAABBCCDD -> read 0x20 returns 0x11BB33DD.
- AW at cycle 0, W at cycle 3, bready=0 for 4 cycles -> write fires at cycle 3; bvalid held with bresp stable. A second AW+W is accepted and held; awready=wready=0 until bready=1; second bvalid follows the next cycle.
- Out of range: write 0x80 and read 0x84 -> bresp=10, rresp=10, rdata=0; word 0x00 unchanged.
- DATA_W=64, SIZE_BYTES='h100: 8 back-to-back reads 0x00..0x38 with rready toggling 1,0 -> all 8 data beats in order, none dropped or duplicated, rdata stable while stalled.
- AXI4L_RAM_RO_EN, RO_BYTES='h40: write to 0x3C -> SLVERR, data unchanged; write to 0x40 -> OKAY, data updated; aresetn=0 pulse mid-stall -> all valids 0, readies 1 the next cycle.

Source files
------------

// File: rtl/axi4l_ram_gen.sv
// AXI4-Lite slave RAM with independent write and read paths, one transaction per cycle each.
// Optional write-protected low region when AXI4L_RAM_RO_EN is defined (size set by RO_BYTES).
module axi4l_ram_gen #(
  parameter int    DATA_W     = 32,
  parameter int    SIZE_BYTES = 'h80,
  parameter int    ADDR_W     = 32,
  parameter int    RO_BYTES   = 'h0,
  parameter string INIT_FILE  = ""
) (
  input  logic                aclk,
  input  logic                aresetn,
  input  logic [ADDR_W-1:0]   awaddr,
  input  logic                awvalid,
  output logic                awready,
  input  logic [DATA_W-1:0]   wdata,
  input  logic [DATA_W/8-1:0] wstrb,
  input  logic                wvalid,
  output logic                wready,
  output logic [1:0]          bresp,
  output logic                bvalid,
  input  logic                bready,
  input  logic [ADDR_W-1:0]   araddr,
  input  logic                arvalid,
  output logic                arready,
  output logic [DATA_W-1:0]   rdata,
  output logic [1:0]          rresp,
  output logic                rvalid,
  input  logic                rready
);

  localparam int STRB_W = DATA_W / 8;
  localparam int LSB    = $clog2(STRB_W);
  localparam int MSB    = $clog2(SIZE_BYTES);
  localparam int IDX_W  = MSB - LSB;
  localparam int WORDS  = 1 << IDX_W;

  // One extra bit so the limit still fits when ADDR_W == $clog2(SIZE_BYTES).
  localparam logic [ADDR_W:0] SIZE_LIM = (ADDR_W + 1)'(SIZE_BYTES);
  localparam logic [ADDR_W:0] RO_LIM   = (ADDR_W + 1)'(RO_BYTES);

`ifdef AXI4L_RAM_RO_EN
  localparam logic RO_EN = 1'b1;
`else
  localparam logic RO_EN = 1'b0;
`endif

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  logic [DATA_W-1:0] mem [WORDS];

  // ---------------------------------------------------------------- write path
  logic              aw_held, w_held;
  logic [ADDR_W-1:0] aw_addr_q;
  logic [DATA_W-1:0] w_data_q;
  logic [STRB_W-1:0] w_strb_q;

  logic              aw_take, w_take, w_fire;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic [STRB_W-1:0] wr_strb;
  logic              wr_oor, wr_ro, mem_we;
  logic [IDX_W-1:0]  wr_idx;

  assign awready = !aw_held;
  assign wready  = !w_held;
  assign aw_take = awvalid && awready;
  assign w_take  = wvalid && wready;

  // A held beat takes priority; otherwise the beat on the bus is used directly.
  assign w_fire  = (aw_held || aw_take) && (w_held || w_take) && (!bvalid || bready);
  assign wr_addr = aw_held ? aw_addr_q : awaddr;
  assign wr_data = w_held ? w_data_q : wdata;
  assign wr_strb = w_held ? w_strb_q : wstrb;
  assign wr_oor  = {1'b0, wr_addr} >= SIZE_LIM;
  assign wr_ro   = RO_EN && ({1'b0, wr_addr} < RO_LIM);
  assign wr_idx  = wr_addr[MSB-1:LSB];
  assign mem_we  = w_fire && !wr_oor && !wr_ro;

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      aw_held <= 1'b0;
      w_held  <= 1'b0;
      bvalid  <= 1'b0;
      bresp   <= RESP_OKAY;
    end else begin
      // NOTE: all sequential state uses non-blocking assignments so every
      // process samples pre-edge values regardless of evaluation order.
      if (w_fire)       aw_held <= 1'b0;
      else if (aw_take) aw_held <= 1'b1;

      if (w_fire)      w_held <= 1'b0;
      else if (w_take) w_held <= 1'b1;

      if (w_fire) begin
        bvalid <= 1'b1;
        bresp  <= (wr_oor || wr_ro) ? RESP_SLVERR : RESP_OKAY;
      end else if (bready) begin
        bvalid <= 1'b0;
      end
    end
  end

  // NOTE: hold registers and memory are pure datapath; their contents are
  // qualified by the held/valid flags, so they carry no reset.
  always_ff @(posedge aclk) begin
    if (aw_take && !w_fire) aw_addr_q <= awaddr;
    if (w_take && !w_fire) begin
      w_data_q <= wdata;
      w_strb_q <= wstrb;
    end
  end

  always_ff @(posedge aclk) begin
    if (mem_we) begin
      for (int i = 0; i < STRB_W; i++) begin
        if (wr_strb[i]) mem[wr_idx][i*8 +: 8] <= wr_data[i*8 +: 8];
      end
    end
  end

  // ----------------------------------------------------------------- read path
  logic              ar_held;
  logic [ADDR_W-1:0] ar_addr_q;
  logic              ar_take, r_fire;
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_oor;
  logic [IDX_W-1:0]  rd_idx;

  assign arready = !ar_held;
  assign ar_take = arvalid && arready;
  assign r_fire  = (ar_held || ar_take) && (!rvalid || rready);
  assign rd_addr = ar_held ? ar_addr_q : araddr;
  assign rd_oor  = {1'b0, rd_addr} >= SIZE_LIM;
  assign rd_idx  = rd_addr[MSB-1:LSB];

  // Memory is read here before this edge's write lands, so a same-word
  // collision returns the pre-write data.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      ar_held <= 1'b0;
      rvalid  <= 1'b0;
      rresp   <= RESP_OKAY;
      rdata   <= '0;
    end else begin
      if (r_fire)       ar_held <= 1'b0;
      else if (ar_take) ar_held <= 1'b1;

      if (r_fire) begin
        rvalid <= 1'b1;
        rresp  <= rd_oor ? RESP_SLVERR : RESP_OKAY;
        rdata  <= rd_oor ? '0 : mem[rd_idx];
      end else if (rready) begin
        rvalid <= 1'b0;
      end
    end
  end

  always_ff @(posedge aclk) begin
    if (ar_take && !r_fire) ar_addr_q <= araddr;
  end

endmodule

// File: tb/tb_axi4l_ram_gen.sv
// Directed bench for axi4l_ram_gen: 32-bit instances (plain and write-protected low 0x40)
// share one stimulus set; a 64-bit instance covers streaming reads under R back-pressure.
module tb_axi4l_ram_gen;

  logic aclk = 1'b0;
  always #5 aclk = ~aclk;
  logic aresetn;

  // Stimulus shared by the 32-bit instances
  logic [31:0] awaddr, wdata, araddr;
  logic [3:0]  wstrb;
  logic        awvalid, wvalid, bready, arvalid, rready;
  // Plain 32-bit instance outputs
  logic        awready, wready, bvalid, arready, rvalid;
  logic [1:0]  bresp, rresp;
  logic [31:0] rdata;
  // Write-protected 32-bit instance outputs
  logic        c_awready, c_wready, c_bvalid, c_arready, c_rvalid;
  logic [1:0]  c_bresp, c_rresp;
  logic [31:0] c_rdata;
  // 64-bit instance
  logic [31:0] x_awaddr, x_araddr;
  logic [63:0] x_wdata, x_rdata;
  logic [7:0]  x_wstrb;
  logic        x_awvalid, x_awready, x_wvalid, x_wready, x_bvalid, x_bready;
  logic        x_arvalid, x_arready, x_rvalid, x_rready;
  logic [1:0]  x_bresp, x_rresp;

  int checks = 0;
  int errors = 0;

  axi4l_ram_gen u_dut (
    .aclk(aclk), .aresetn(aresetn),
    .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .araddr(araddr), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready)
  );

  axi4l_ram_gen #(.RO_BYTES('h40)) u_dut_ro (
    .aclk(aclk), .aresetn(aresetn),
    .awaddr(awaddr), .awvalid(awvalid), .awready(c_awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(c_wready),
    .bresp(c_bresp), .bvalid(c_bvalid), .bready(bready),
    .araddr(araddr), .arvalid(arvalid), .arready(c_arready),
    .rdata(c_rdata), .rresp(c_rresp), .rvalid(c_rvalid), .rready(rready)
  );

  axi4l_ram_gen #(.DATA_W(64), .SIZE_BYTES('h100)) u_dut_64 (
    .aclk(aclk), .aresetn(aresetn),
    .awaddr(x_awaddr), .awvalid(x_awvalid), .awready(x_awready),
    .wdata(x_wdata), .wstrb(x_wstrb), .wvalid(x_wvalid), .wready(x_wready),
    .bresp(x_bresp), .bvalid(x_bvalid), .bready(x_bready),
    .araddr(x_araddr), .arvalid(x_arvalid), .arready(x_arready),
    .rdata(x_rdata), .rresp(x_rresp), .rvalid(x_rvalid), .rready(x_rready)
  );

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, errors so far %0d", errors);
    $fatal(1, "watchdog");
  end

  // AW+W in one cycle with bready=1; returns the B beat seen one cycle later.
  task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                          output logic got, output logic [1:0] resp, output logic [1:0] c_resp);
    @(negedge aclk);
    awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
    @(posedge aclk);
    @(negedge aclk);
    awvalid = 1'b0; wvalid = 1'b0;
    got = bvalid; resp = bresp; c_resp = c_bresp;
  endtask

  task automatic do_read(input logic [31:0] a, output logic got, output logic [31:0] d,
                         output logic [1:0] resp, output logic [31:0] c_d);
    @(negedge aclk);
    araddr = a; arvalid = 1'b1; rready = 1'b1;
    @(posedge aclk);
    @(negedge aclk);
    arvalid = 1'b0;
    got = rvalid; d = rdata; resp = rresp; c_d = c_rdata;
  endtask

  task automatic test_reset();
    aresetn = 1'b0;
    awaddr = '0; wdata = '0; wstrb = '0; araddr = '0;
    awvalid = 1'b0; wvalid = 1'b0; bready = 1'b0; arvalid = 1'b0; rready = 1'b0;
    x_awaddr = '0; x_wdata = '0; x_wstrb = '0; x_araddr = '0;
    x_awvalid = 1'b0; x_wvalid = 1'b0; x_bready = 1'b0; x_arvalid = 1'b0; x_rready = 1'b0;
    repeat (3) @(posedge aclk);
    @(negedge aclk);
    aresetn = 1'b1;
    checks++; if ({awready, wready, arready} !== 3'b111) begin errors++;
      $display("FAIL reset_readies: got %b expected 111", {awready, wready, arready}); end
    checks++; if ({bvalid, rvalid} !== 2'b00) begin errors++;
      $display("FAIL reset_valids: got %b expected 00", {bvalid, rvalid}); end
    checks++; if ({bresp, rresp} !== 4'b0000) begin errors++;
      $display("FAIL reset_resps: got %b expected 0000", {bresp, rresp}); end
    checks++; if (rdata !== 32'h0) begin errors++;
      $display("FAIL reset_rdata: got %h expected 00000000", rdata); end
    checks++; if ({x_arready, x_rvalid, x_bvalid} !== 3'b100) begin errors++;
      $display("FAIL reset_64: got %b expected 100", {x_arready, x_rvalid, x_bvalid}); end
  endtask

  task automatic test_basic();
    logic got; logic [1:0] resp, cr; logic [31:0] d, cd;
    do_write(32'h10, 32'hDEADBEEF, 4'hF, got, resp, cr);
    checks++; if (got !== 1'b1 || resp !== 2'b00) begin errors++;
      $display("FAIL basic_wr: got bvalid=%b bresp=%b expected 1 00", got, resp); end
    do_read(32'h10, got, d, resp, cd);
    checks++; if (got !== 1'b1 || resp !== 2'b00 || d !== 32'hDEADBEEF) begin errors++;
      $display("FAIL basic_rd: got %b %b %h expected 1 00 deadbeef", got, resp, d); end
    do_read(32'h13, got, d, resp, cd);
    checks++; if (d !== 32'hDEADBEEF) begin errors++;
      $display("FAIL unaligned_rd: got %h expected deadbeef", d); end
  endtask

  task automatic test_partial_strobe();
    logic got; logic [1:0] resp, cr; logic [31:0] d, cd;
    do_write(32'h20, 32'h11223344, 4'hF, got, resp, cr);
    do_write(32'h20, 32'hAABBCCDD, 4'b0101, got, resp, cr);
    do_read(32'h20, got, d, resp, cd);
    checks++; if (d !== 32'h11BB33DD) begin errors++;
      $display("FAIL partial_strobe: got %h expected 11bb33dd", d); end
  endtask

  task automatic test_split_b_stall();
    logic got; logic [1:0] resp; logic [31:0] d, cd;
    @(negedge aclk);
    awaddr = 32'h30; awvalid = 1'b1; wvalid = 1'b0; bready = 1'b0;
    @(posedge aclk);
    @(negedge aclk);
    awvalid = 1'b0;
    checks++; if (awready !== 1'b0 || bvalid !== 1'b0) begin errors++;
      $display("FAIL aw_held: got awready=%b bvalid=%b expected 0 0", awready, bvalid); end
    repeat (2) @(posedge aclk);
    @(negedge aclk);
    checks++; if (wready !== 1'b1 || awready !== 1'b0) begin errors++;
      $display("FAIL w_wait: got wready=%b awready=%b expected 1 0", wready, awready); end
    wdata = 32'h55667788; wstrb = 4'hF; wvalid = 1'b1;
    @(posedge aclk);
    @(negedge aclk);
    wvalid = 1'b0;
    checks++; if (bvalid !== 1'b1 || bresp !== 2'b00 || awready !== 1'b1) begin errors++;
      $display("FAIL late_w_fire: got bvalid=%b bresp=%b awready=%b expected 1 00 1",
               bvalid, bresp, awready); end
    awaddr = 32'h34; wdata = 32'h99AABBCC; awvalid = 1'b1; wvalid = 1'b1;
    @(posedge aclk);
    @(negedge aclk);
    awvalid = 1'b0; wvalid = 1'b0;
    checks++; if ({awready, wready, bvalid, bresp} !== 5'b00100) begin errors++;
      $display("FAIL b_stall_hold: got %b expected 00100", {awready, wready, bvalid, bresp}); end
    @(posedge aclk);
    @(negedge aclk);
    checks++; if ({awready, wready, bvalid, bresp} !== 5'b00100) begin errors++;
      $display("FAIL b_stall_stable: got %b expected 00100", {awready, wready, bvalid, bresp}); end
    bready = 1'b1;
    @(posedge aclk);
    @(negedge aclk);
    checks++; if ({awready, wready, bvalid} !== 3'b111) begin errors++;
      $display("FAIL second_b: got %b expected 111", {awready, wready, bvalid}); end
    @(posedge aclk);
    @(negedge aclk);
    checks++; if (bvalid !== 1'b0) begin errors++;
      $display("FAIL b_drain: got bvalid=%b expected 0", bvalid); end
    do_read(32'h30, got, d, resp, cd);
    checks++; if (d !== 32'h55667788) begin errors++;
      $display("FAIL split_data0: got %h expected 55667788", d); end
    do_read(32'h34, got, d, resp, cd);
    checks++; if (d !== 32'h99AABBCC) begin errors++;
      $display("FAIL split_data1: got %h expected 99aabbcc", d); end
  endtask

  task automatic test_out_of_range();
    logic got; logic [1:0] resp, cr; logic [31:0] d, cd;
    do_write(32'h00, 32'hCAFEF00D, 4'hF, got, resp, cr);
    do_write(32'h80, 32'h12345678, 4'hF, got, resp, cr);
    checks++; if (got !== 1'b1 || resp !== 2'b10) begin errors++;
      $display("FAIL oor_wr: got %b %b expected 1 10", got, resp); end
    do_read(32'h84, got, d, resp, cd);
    checks++; if (got !== 1'b1 || resp !== 2'b10 || d !== 32'h0) begin errors++;
      $display("FAIL oor_rd: got %b %b %h expected 1 10 00000000", got, resp, d); end
    do_read(32'h00, got, d, resp, cd);
    checks++; if (d !== 32'hCAFEF00D) begin errors++;
      $display("FAIL oor_alias: got %h expected cafef00d", d); end
    do_write(32'h7C, 32'h7C7C7C7C, 4'hF, got, resp, cr);
    checks++; if (resp !== 2'b00) begin errors++;
      $display("FAIL last_word_wr: got %b expected 00", resp); end
    do_read(32'h7C, got, d, resp, cd);
    checks++; if (d !== 32'h7C7C7C7C || resp !== 2'b00) begin errors++;
      $display("FAIL last_word_rd: got %h %b expected 7c7c7c7c 00", d, resp); end
  endtask

  task automatic test_collision();
    logic got; logic [1:0] resp, cr; logic [31:0] d, cd;
    do_write(32'h40, 32'h0BADC0DE, 4'hF, got, resp, cr);
    @(negedge aclk);
    awaddr = 32'h40; wdata = 32'h600DCAFE; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
    bready = 1'b1; araddr = 32'h40; arvalid = 1'b1; rready = 1'b1;
    @(posedge aclk);
    @(negedge aclk);
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    checks++; if (rvalid !== 1'b1 || bvalid !== 1'b1 || rdata !== 32'h0BADC0DE) begin errors++;
      $display("FAIL collision_old: got %b %b %h expected 1 1 0badc0de", rvalid, bvalid, rdata); end
    do_read(32'h40, got, d, resp, cd);
    checks++; if (d !== 32'h600DCAFE) begin errors++;
      $display("FAIL collision_new: got %h expected 600dcafe", d); end
  endtask

  task automatic test_read_only();
    logic got; logic [1:0] resp, cr, exp_cr; logic [31:0] d, cd, c_before, exp_cd;
    do_read(32'h3C, got, d, resp, c_before);
    do_write(32'h3C, 32'h13579BDF, 4'hF, got, resp, cr);
`ifdef AXI4L_RAM_RO_EN
    exp_cr = 2'b10;
`else
    exp_cr = 2'b00;
`endif
    checks++; if (resp !== 2'b00 || cr !== exp_cr) begin errors++;
      $display("FAIL ro_wr_resp: got %b %b expected 00 %b", resp, cr, exp_cr); end
    do_read(32'h3C, got, d, resp, cd);
`ifdef AXI4L_RAM_RO_EN
    exp_cd = c_before;
`else
    exp_cd = 32'h13579BDF;
`endif
    checks++; if (d !== 32'h13579BDF || cd !== exp_cd) begin errors++;
      $display("FAIL ro_rd: got %h %h expected 13579bdf %h", d, cd, exp_cd); end
    do_write(32'h40, 32'h2468ACE0, 4'hF, got, resp, cr);
    checks++; if (cr !== 2'b00) begin errors++;
      $display("FAIL ro_edge_wr: got %b expected 00", cr); end
    do_read(32'h40, got, d, resp, cd);
    checks++; if (cd !== 32'h2468ACE0) begin errors++;
      $display("FAIL ro_edge_rd: got %h expected 2468ace0", cd); end
  endtask

  task automatic test_reset_mid_stall();
    logic got; logic [1:0] resp, cr; logic [31:0] d, cd;
    do_write(32'h54, 32'h0, 4'hF, got, resp, cr);
    @(negedge aclk);
    bready = 1'b0; rready = 1'b0;
    awaddr = 32'h50; wdata = 32'h1; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
    araddr = 32'h50; arvalid = 1'b1;
    @(posedge aclk);
    @(negedge aclk);
    awaddr = 32'h54; wdata = 32'hFFFFFFFF; araddr = 32'h54;
    @(posedge aclk);
    @(negedge aclk);
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    checks++; if ({bvalid, rvalid, awready, wready, arready} !== 5'b11000) begin errors++;
      $display("FAIL stall_setup: got %b expected 11000", {bvalid, rvalid, awready, wready, arready}); end
    aresetn = 1'b0;
    @(posedge aclk);
    @(negedge aclk);
    aresetn = 1'b1;
    checks++; if ({bvalid, rvalid, awready, wready, arready} !== 5'b00111) begin errors++;
      $display("FAIL mid_reset: got %b expected 00111", {bvalid, rvalid, awready, wready, arready}); end
    checks++; if ({c_bvalid, c_rvalid, c_awready, c_wready, c_arready} !== 5'b00111) begin errors++;
      $display("FAIL mid_reset_ro: got %b expected 00111",
               {c_bvalid, c_rvalid, c_awready, c_wready, c_arready}); end
    bready = 1'b1; rready = 1'b1;
    repeat (3) @(posedge aclk);
    @(negedge aclk);
    checks++; if ({bvalid, rvalid} !== 2'b00) begin errors++;
      $display("FAIL post_reset_idle: got %b expected 00", {bvalid, rvalid}); end
    do_read(32'h50, got, d, resp, cd);
    checks++; if (d !== 32'h1) begin errors++;
      $display("FAIL pre_reset_write: got %h expected 00000001", d); end
    do_read(32'h54, got, d, resp, cd);
    checks++; if (d !== 32'h0) begin errors++;
      $display("FAIL held_write_dropped: got %h expected 00000000", d); end
  endtask

  function automatic logic [63:0] x_pattern(input int i);
    return {32'hC0DE0000 + 32'(i), 32'h0000F000 + 32'(i * 3)};
  endfunction

  task automatic test_back_to_back();
    for (int i = 0; i < 8; i++) begin
      @(negedge aclk);
      checks++; if ({x_awready, x_wready} !== 2'b11) begin errors++;
        $display("FAIL b2b_wr_ready[%0d]: got %b expected 11", i, {x_awready, x_wready}); end
      if (i > 0) begin
        checks++; if (x_bvalid !== 1'b1 || x_bresp !== 2'b00) begin errors++;
          $display("FAIL b2b_bresp[%0d]: got %b %b expected 1 00", i, x_bvalid, x_bresp); end
      end
      x_awaddr = 32'(i * 8); x_wdata = x_pattern(i); x_wstrb = 8'hFF;
      x_awvalid = 1'b1; x_wvalid = 1'b1; x_bready = 1'b1;
    end
    @(negedge aclk);
    x_awvalid = 1'b0; x_wvalid = 1'b0;

    fork
      begin : producer
        for (int i = 0; i < 8; i++) begin
          int n = 0;
          @(negedge aclk);
          x_araddr = 32'(i * 8); x_arvalid = 1'b1;
          while (x_arready !== 1'b1 && n < 20) begin
            @(negedge aclk);
            n++;
          end
          if (n == 20) begin
            errors++;
            $display("FAIL b2b_ar_timeout[%0d]: arready stayed %b", i, x_arready);
          end
          @(posedge aclk);
        end
        @(negedge aclk);
        x_arvalid = 1'b0;
      end
      begin : consumer
        int k = 0;
        int cyc = 0;
        logic stalled = 1'b0;
        logic rr = 1'b1;
        logic [63:0] prev = '0;
        while (k < 8 && cyc < 100) begin
          @(negedge aclk);
          cyc++;
          if (stalled) begin
            checks++; if (x_rvalid !== 1'b1 || x_rdata !== prev) begin errors++;
              $display("FAIL b2b_stable: got %b %h expected 1 %h", x_rvalid, x_rdata, prev); end
          end
          x_rready = rr;
          rr = !rr;
          if (x_rvalid === 1'b1 && x_rready) begin
            checks++; if (x_rdata !== x_pattern(k) || x_rresp !== 2'b00) begin errors++;
              $display("FAIL b2b_beat[%0d]: got %h %b expected %h 00", k, x_rdata, x_rresp, x_pattern(k)); end
            k++;
            stalled = 1'b0;
          end else if (x_rvalid === 1'b1) begin
            stalled = 1'b1;
            prev = x_rdata;
          end else begin
            stalled = 1'b0;
          end
        end
        checks++; if (k != 8) begin errors++;
          $display("FAIL b2b_count: got %0d beats expected 8", k); end
      end
    join
    @(negedge aclk);
    x_rready = 1'b1;
    repeat (2) @(posedge aclk);
    @(negedge aclk);
    checks++; if (x_rvalid !== 1'b0) begin errors++;
      $display("FAIL b2b_no_extra: got rvalid=%b expected 0", x_rvalid); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_partial_strobe();
    test_split_b_stall();
    test_out_of_range();
    test_collision();
    test_read_only();
    test_reset_mid_stall();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
